// File: rtl/m31_pkg.sv
// m31_pkg: shared M31 field types, constants and modular arithmetic helpers
package m31_pkg;

    localparam bit [30:0] P_M31 = 31'h7FFF_FFFF;

    typedef bit [30:0] m31_t;

    typedef enum logic [1:0] {IDLE, CLR, ACC, OUT} seq_state_e;

    // a + b mod p, both operands reduced
    function automatic m31_t m31_add(input m31_t a, input m31_t b);
        logic [31:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, P_M31}) ? 31'(s - {1'b0, P_M31}) : s[30:0];
    endfunction

    // a * b mod p using two Mersenne folds; second fold cannot exceed p
    function automatic m31_t m31_mul(input m31_t a, input m31_t b);
        logic [61:0] x;
        logic [31:0] s;
        logic [30:0] t;
        x = 62'(a) * 62'(b);
        s = {1'b0, x[30:0]} + {1'b0, x[61:31]};
        t = s[30:0] + 31'(s[31]);
        return (t == P_M31) ? 31'd0 : t;
    endfunction

endpackage

// File: rtl/m31_row_rotate.sv
// m31_row_rotate: builds circulant row r, element c = row0[(c - r) mod N]
module m31_row_rotate #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] row0_i,
    input  logic [$clog2(VECTOR_SIZE)-1:0]         r_i,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] rot_o
);

    localparam int IW = $clog2(VECTOR_SIZE);

    for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_col
        assign rot_o[c] = row0_i[IW'(c) - r_i];
    end

endmodule

// File: rtl/vector_dot_product_mc.sv
// vector_dot_product_mc: multi-cycle M31 dot product, one multiply-accumulate per cycle
module vector_dot_product_mc
    import m31_pkg::*;
#(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec1_i,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec2_i,
    output logic [WORD_WIDTH-1:0]                  result_o,
    output logic                                   valid_o
);

    localparam int IW = $clog2(VECTOR_SIZE);

    m31_t          acc_q;
    logic [IW-1:0] k_q;
    m31_t          sum;

    // The last term is folded in combinationally so the result is ready N-1 cycles after reset
    assign sum      = m31_add(acc_q, m31_mul(vec1_i[k_q], vec2_i[k_q]));
    assign valid_o  = k_q == IW'(VECTOR_SIZE - 1);
    assign result_o = sum;

    // Reset preloads term 0; afterwards accumulate one term per cycle until the last index
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= m31_mul(vec1_i[0], vec2_i[0]);
            k_q   <= IW'(1);
        end else if (!valid_o) begin
            acc_q <= sum;
            k_q   <= k_q + IW'(1);
        end
    end

endmodule

// File: rtl/m31_circulant_matvec_seq.sv
// m31_circulant_matvec_seq: row-by-row circulant matrix x vector product over M31
module m31_circulant_matvec_seq
    import m31_pkg::*;
#(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] row0,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] in_state,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] out_state,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int IW = $clog2(VECTOR_SIZE);

    seq_state_e                             state_q, state_d;
    logic [IW-1:0]                          r_q, r_d;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] x_q, x_d;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] out_q, out_d;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] row_rot;
    logic [WORD_WIDTH-1:0]                  dp_result;
    logic                                   dp_valid;
    logic                                   last_row;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign out_state = out_q;
    assign last_row  = r_q == IW'(VECTOR_SIZE - 1);

    m31_row_rotate #(.WORD_WIDTH(WORD_WIDTH), .VECTOR_SIZE(VECTOR_SIZE)) u_rotate (
        .row0_i (row0),
        .r_i    (r_q),
        .rot_o  (row_rot)
    );

    vector_dot_product_mc #(.WORD_WIDTH(WORD_WIDTH), .VECTOR_SIZE(VECTOR_SIZE)) u_dp (
        .clk      (clk),
        .reset    (reset | (state_q == CLR)),
        .vec1_i   (row_rot),
        .vec2_i   (x_q),
        .result_o (dp_result),
        .valid_o  (dp_valid)
    );

    // State, row index, captured input and result buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            x_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            out_q   <= out_d;
        end
    end

    // Sequencing: clear the MACC per row, store each row result, hold the vector until taken
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = in_state;
                r_d     = '0;
                state_d = CLR;
            end
            CLR:  state_d = ACC;
            ACC:  if (dp_valid) begin
                out_d[r_q] = dp_result;
                r_d        = last_row ? r_q : r_q + IW'(1);
                state_d    = last_row ? OUT : CLR;
            end
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m31_circulant_matvec_seq.sv
// tb_m31_circulant_matvec_seq: directed tests of the circulant matvec sequencer
module tb_m31_circulant_matvec_seq;

    localparam int N = 16;
    localparam logic [30:0] P = 31'h7FFF_FFFF;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0][30:0]  row0 = '0;
    logic [N-1:0][30:0]  in_state = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N-1:0][30:0]  out_state;
    logic                out_valid;
    logic                out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m31_circulant_matvec_seq #(.WORD_WIDTH(31), .VECTOR_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .row0      (row0),
        .in_state  (in_state),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic run_job(input logic [N-1:0][30:0] r0, input logic [N-1:0][30:0] x, output int cyc);
        @(negedge clk);
        row0     = r0;
        in_state = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = '1;
        wait_out(cyc);
    endtask

    task automatic take_output();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (out_state !== '0) begin errors++; $display("FAIL reset_out_state got %h exp 0", out_state); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        r0 = '0;
        r0[0] = 31'd1;
        for (int i = 0; i < N; i++) x[i] = 31'(i + 1);
        run_job(r0, x, cyc);
        checks++;
        if (cyc !== 256) begin errors++; $display("FAIL identity_latency got %0d exp 256", cyc); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_state[i] !== 31'(i + 1)) begin errors++; $display("FAIL identity_out[%0d] got %0d exp %0d", i, out_state[i], i + 1); end
        end
        take_output();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL identity_transfer got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_all_ones();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        for (int i = 0; i < N; i++) begin r0[i] = 31'd1; x[i] = 31'(i + 1); end
        run_job(r0, x, cyc);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_timeout got ov=%b exp 1", out_valid); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_state[i] !== 31'd136) begin errors++; $display("FAIL ones_out[%0d] got %0d exp 136", i, out_state[i]); end
        end
        take_output();
    endtask

    task automatic test_neg_one();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        r0 = '0;
        r0[0] = P - 31'd1;
        for (int i = 0; i < N; i++) x[i] = 31'd2;
        run_job(r0, x, cyc);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL negone_timeout got ov=%b exp 1", out_valid); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_state[i] !== 31'h7FFF_FFFD) begin errors++; $display("FAIL negone_out[%0d] got %h exp 7ffffffd", i, out_state[i]); end
        end
        take_output();
    endtask

    task automatic test_shift();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        r0 = '0;
        r0[1] = 31'd1;
        for (int i = 0; i < N; i++) x[i] = 31'(i + 1);
        run_job(r0, x, cyc);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL shift_timeout got ov=%b exp 1", out_valid); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_state[i] !== 31'(((i + 1) % N) + 1)) begin errors++; $display("FAIL shift_out[%0d] got %0d exp %0d", i, out_state[i], ((i + 1) % N) + 1); end
        end
        take_output();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        for (int i = 0; i < N; i++) begin r0[i] = 31'd1; x[i] = 31'(i + 1); end
        run_job(r0, x, cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) in_state[i] = 31'd5;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_handshake[%0d] got ov=%b ir=%b exp ov=1 ir=0", k, out_valid, in_ready); end
            checks++;
            if (out_state[0] !== 31'd136 || out_state[N-1] !== 31'd136) begin errors++; $display("FAIL hold_stable[%0d] got %0d/%0d exp 136", k, out_state[0], out_state[N-1]); end
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ir=%b exp 0", in_ready); end
        wait_out(cyc);
        checks++;
        if (cyc !== 256) begin errors++; $display("FAIL b2b_latency got %0d exp 256", cyc); end
        checks++;
        if (out_state[0] !== 31'd80 || out_state[N-1] !== 31'd80) begin errors++; $display("FAIL b2b_out got %0d/%0d exp 80", out_state[0], out_state[N-1]); end
        take_output();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0][30:0] r0, x;
        int cyc;
        for (int i = 0; i < N; i++) begin r0[i] = 31'd1; x[i] = 31'd7; end
        @(negedge clk);
        row0     = r0;
        in_state = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_hs got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
        checks++;
        if (out_state !== '0) begin errors++; $display("FAIL midreset_out got %h exp 0", out_state); end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) x[i] = 31'(i + 1);
        run_job(r0, x, cyc);
        checks++;
        if (cyc !== 256) begin errors++; $display("FAIL midreset_latency got %0d exp 256", cyc); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_state[i] !== 31'd136) begin errors++; $display("FAIL midreset_out[%0d] got %0d exp 136", i, out_state[i]); end
        end
        take_output();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones();
        test_neg_one();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
